uart_cmd_decoder: RTL and testbench

- Sits between the UART receiver and the two motor drivers.
- Consumes received bytes and assembles 3-byte command frames: header, command, checksum.
- Validates each frame and drives registered left/right 2-bit motor commands.
- A watchdog forces both motors to stop when valid frames stop arriving.

---
 rtl/motor_pkg.sv | 27 ++
 rtl/tick_timer.sv | 33 +++
 rtl/uart_cmd_decoder.sv | 119 +++++++++++
 tb/tb_uart_cmd_decoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared types and constants for the UART motor command path.
`default_nettype none

package motor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GOT_HDR = 2'd1,
      GOT_CMD = 2'd2
   } state_t;

   localparam logic [1:0] MOT_STOP = 2'b00;
   localparam logic [7:0] DEF_HDR  = 8'hA5;

   localparam int LCMD_HI = 5;
   localparam int LCMD_LO = 4;
   localparam int RCMD_HI = 3;
   localparam int RCMD_LO = 2;

   // A command is usable only with its reserved bits clear and a matching inverted checksum.
   function automatic logic frame_ok(input logic [7:0] cmd, input logic [7:0] chk);
      return (chk == ~cmd) && (cmd[7:6] == 2'b00) && (cmd[1:0] == 2'b00);
   endfunction

endpackage

`default_nettype wire

// File: rtl/tick_timer.sv
// Saturating cycle counter; expired is high while the count sits at TICKS-1.
`default_nettype none

module tick_timer #(
   parameter int TICKS = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int         W    = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [W-1:0] LAST = W'(TICKS - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != LAST)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
// Assembles header/command/checksum frames from UART bytes into registered motor commands,
// with an inter-byte gap abort and a watchdog that stops both motors.
`default_nettype none

module uart_cmd_decoder
   import motor_pkg::*;
#(
   parameter logic [7:0] HDR        = DEF_HDR,
   parameter int         GAP_TICKS  = 50_000,
   parameter int         WDOG_TICKS = 5_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [1:0] lcmd,
   output logic [1:0] rcmd,
   output logic       cmd_valid,
   output logic       frame_err,
   output logic       timeout,
   output logic [7:0] frame_cnt
);

   state_t     state_q;
   logic [7:0] cmd_q;
   logic [1:0] lcmd_q;
   logic [1:0] rcmd_q;
   logic       cmd_valid_q;
   logic       frame_err_q;
   logic       timeout_q;
   logic [7:0] frame_cnt_q;

   logic in_frame;
   logic chk_ok;
   logic accept;
   logic gap_exp;
   logic gap_abort;
   logic wdog_exp;

   assign in_frame  = (state_q != IDLE);
   assign chk_ok    = frame_ok(cmd_q, rx_data);
   assign accept    = rx_valid && (state_q == GOT_CMD) && chk_ok;
   // A byte landing on the expiry cycle still counts, so the abort needs a quiet line.
   assign gap_abort = in_frame && !rx_valid && gap_exp;

   tick_timer #(.TICKS(GAP_TICKS)) u_gap (
      .clk     (clk),
      .reset   (reset),
      .clr     (rx_valid || !in_frame),
      .en      (in_frame),
      .expired (gap_exp)
   );

   tick_timer #(.TICKS(WDOG_TICKS)) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (accept),
      .en      (1'b1),
      .expired (wdog_exp)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         lcmd_q      <= MOT_STOP;
         rcmd_q      <= MOT_STOP;
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         timeout_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         cmd_valid_q <= accept;
         frame_err_q <= 1'b0;

         if (rx_valid) begin
            case (state_q)
               IDLE: begin
                  if (rx_data == HDR) state_q <= GOT_HDR;
               end
               GOT_HDR: begin
                  cmd_q   <= rx_data;
                  state_q <= GOT_CMD;
               end
               GOT_CMD: begin
                  state_q <= IDLE;
                  if (!chk_ok) frame_err_q <= 1'b1;
               end
               default: state_q <= IDLE;
            endcase
         end else if (gap_abort) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
         end

         // An accept on the expiry cycle takes priority over the forced stop.
         if (accept) begin
            lcmd_q      <= cmd_q[LCMD_HI:LCMD_LO];
            rcmd_q      <= cmd_q[RCMD_HI:RCMD_LO];
            frame_cnt_q <= frame_cnt_q + 8'd1;
            timeout_q   <= 1'b0;
         end else if (wdog_exp) begin
            lcmd_q    <= MOT_STOP;
            rcmd_q    <= MOT_STOP;
            timeout_q <= 1'b1;
         end
      end
   end

   assign lcmd      = lcmd_q;
   assign rcmd      = rcmd_q;
   assign cmd_valid = cmd_valid_q;
   assign frame_err = frame_err_q;
   assign timeout   = timeout_q;
   assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
// Directed and randomized frame traffic against a cycle-level behavioural model of the decoder.
`default_nettype none

module tb_uart_cmd_decoder;

   localparam int         GAP  = 16;
   localparam int         WDOG = 200;
   localparam logic [7:0] HDR  = 8'hA5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [1:0] lcmd, rcmd;
   logic       cmd_valid, frame_err, timeout;
   logic [7:0] frame_cnt;

   int n_vec = 0;
   int n_err = 0;

   uart_cmd_decoder #(
      .HDR        (HDR),
      .GAP_TICKS  (GAP),
      .WDOG_TICKS (WDOG)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .lcmd      (lcmd),
      .rcmd      (rcmd),
      .cmd_valid (cmd_valid),
      .frame_err (frame_err),
      .timeout   (timeout),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: frame position, idle cycles inside a frame, cycles since the last accept.
   int         m_pos = 0;
   int         m_gap = 0;
   int         m_since = 0;
   logic [7:0] m_cmd = 8'h00;
   logic [7:0] m_cnt = 8'h00;
   logic [1:0] m_l = 2'b00, m_r = 2'b00;
   logic       m_cv = 1'b0, m_fe = 1'b0, m_to = 1'b0;

   always @(posedge clk or negedge reset) begin
      logic acc, err;
      if (!reset) begin
         m_pos = 0; m_gap = 0; m_since = 0; m_cmd = 8'h00; m_cnt = 8'h00;
         m_l = 2'b00; m_r = 2'b00; m_cv = 1'b0; m_fe = 1'b0; m_to = 1'b0;
      end else begin
         acc = 1'b0;
         err = 1'b0;
         if (rx_valid) begin
            if (m_pos == 0) begin
               if (rx_data == HDR) m_pos = 1;
            end else if (m_pos == 1) begin
               m_cmd = rx_data;
               m_pos = 2;
            end else begin
               if (rx_data == ~m_cmd && m_cmd[7:6] == 2'b00 && m_cmd[1:0] == 2'b00) acc = 1'b1;
               else err = 1'b1;
               m_pos = 0;
            end
            m_gap = 0;
         end else if (m_pos != 0) begin
            if (m_gap == GAP - 1) begin
               err = 1'b1;
               m_pos = 0;
               m_gap = 0;
            end else begin
               m_gap++;
            end
         end else begin
            m_gap = 0;
         end

         if (acc) begin
            m_l = m_cmd[5:4];
            m_r = m_cmd[3:2];
            m_cnt = m_cnt + 8'd1;
            m_to = 1'b0;
            m_since = 0;
         end else begin
            if (m_since >= WDOG - 1) begin
               m_to = 1'b1;
               m_l = 2'b00;
               m_r = 2'b00;
            end
            if (m_since < WDOG - 1) m_since++;
         end
         m_cv = acc;
         m_fe = err;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("cmd_valid", cmd_valid, m_cv);
         chk("frame_err", frame_err, m_fe);
         chk("timeout",   timeout,   m_to);
         chk("lcmd",      lcmd,      m_l);
         chk("rcmd",      rcmd,      m_r);
         chk("frame_cnt", frame_cnt, m_cnt);
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = $urandom_range(0, 255);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic int pick_gap();
      return ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(14, 17);
   endfunction

   task automatic send_frame(input logic [7:0] h, input logic [7:0] c, input logic [7:0] s);
      send_byte(h);
      tick(pick_gap());
      send_byte(c);
      tick(pick_gap());
      send_byte(s);
   endtask

   initial begin
      int         cyc;
      int         kind;
      logic [7:0] c, s;

      @(posedge clk);
      #1;
      chk("reset_lcmd", lcmd, 2'b00);
      chk("reset_cnt", frame_cnt, 8'd0);
      do_reset();

      // Valid frame, then bad checksum, then stray bytes while idle.
      send_byte(8'hA5); send_byte(8'h14); send_byte(8'hEB);
      chk("valid_lcmd", lcmd, 2'b01);
      chk("valid_rcmd", rcmd, 2'b01);
      chk("valid_pulse", cmd_valid, 1'b1);
      chk("valid_cnt", frame_cnt, 8'd1);
      chk("valid_noerr", frame_err, 1'b0);
      send_byte(8'hA5); send_byte(8'h24); send_byte(8'h00);
      chk("badsum_err", frame_err, 1'b1);
      chk("badsum_lcmd", lcmd, 2'b01);
      chk("badsum_cnt", frame_cnt, 8'd1);
      send_byte(8'h24); send_byte(8'hDB);
      chk("idle_ignore_cv", cmd_valid, 1'b0);
      chk("idle_ignore_cnt", frame_cnt, 8'd1);

      // Reserved bits set, then resync past a junk byte.
      send_byte(8'hA5); send_byte(8'h84); send_byte(8'h7B);
      chk("resv_err", frame_err, 1'b1);
      send_byte(8'h37); send_byte(8'hA5); send_byte(8'h20); send_byte(8'hDF);
      chk("resync_lcmd", lcmd, 2'b10);
      chk("resync_rcmd", rcmd, 2'b00);
      chk("resync_cnt", frame_cnt, 8'd2);

      // Gap abort after a lone header.
      send_byte(8'hA5);
      cyc = 0;
      for (int k = 1; k <= 40; k++) begin
         tick(1);
         if (frame_err) begin
            cyc = k;
            break;
         end
      end
      chk("gap_latency", cyc, 16);
      send_byte(8'h14); send_byte(8'hEB);
      chk("gap_ignore_cnt", frame_cnt, 8'd2);

      // Watchdog expiry and recovery.
      send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hC3);
      chk("wd_lcmd", lcmd, 2'b11);
      chk("wd_rcmd", rcmd, 2'b11);
      tick(199);
      chk("wd_before", timeout, 1'b0);
      tick(1);
      chk("wd_timeout", timeout, 1'b1);
      chk("wd_stop_l", lcmd, 2'b00);
      chk("wd_stop_r", rcmd, 2'b00);
      send_byte(8'hA5); send_byte(8'h14); send_byte(8'hEB);
      chk("wd_clear", timeout, 1'b0);
      chk("wd_new_lcmd", lcmd, 2'b01);

      // Asynchronous reset in the middle of a frame.
      send_byte(8'hA5);
      #2 reset = 1'b0;
      #1;
      chk("arst_lcmd", lcmd, 2'b00);
      chk("arst_rcmd", rcmd, 2'b00);
      chk("arst_cnt", frame_cnt, 8'd0);
      chk("arst_to", timeout, 1'b0);
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
      send_byte(8'h14); send_byte(8'hEB);
      chk("arst_noacc_cv", cmd_valid, 1'b0);
      chk("arst_noacc_cnt", frame_cnt, 8'd0);

      // Randomized traffic, checked every cycle by the model.
      for (int it = 0; it < 400; it++) begin
         kind = $urandom_range(0, 9);
         c = {2'b00, 4'($urandom), 2'b00};
         case (kind)
            0, 1, 2, 3: send_frame(HDR, c, ~c);
            4: begin
               s = ~c ^ 8'(1 << $urandom_range(0, 7));
               send_frame(HDR, c, s);
            end
            5: begin
               c = 8'($urandom);
               send_frame(HDR, c, ~c);
            end
            6: send_byte(8'($urandom));
            7: tick($urandom_range(0, 5));
            8: begin
               if ($urandom_range(0, 3) == 0) tick(210);
               else tick($urandom_range(14, 18));
            end
            default: send_frame(HDR, HDR, ~HDR);
         endcase
      end
      tick(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
